// File: rtl/tkm_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
// Contents:
//   tkm_sa_state_e    control FSM states
//   TKM_SA_MAX_WIDTH  largest supported operand width
package tkm_pkg;

  localparam int unsigned TKM_SA_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tkm_sa_state_e;

endpackage

// File: rtl/tkm_serial_addsub_if.sv
// Operand/result handshake bundle for tkm_serial_addsub.
// Signals:
//   in_valid/in_ready    operand transfer handshake
//   op_a, op_b, sub      operands and mode (sub=1 selects A-B)
//   out_valid/out_ready  result transfer handshake
//   sum, carry_out, overflow  result
// Modports: master drives operands and consumes results; slave is the adder.
interface tkm_serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/tkm_full_adder.sv
// Single-bit combinational full adder, the cell time-multiplexed by the serial adder.
// Ports:
//   a, b, ci  addend bits and carry in
//   s, co     sum bit and carry out
module tkm_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/tkm_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor. One full adder is reused over WIDTH
// cycles, LSB first. Subtraction is A + ~B + 1 with the +1 supplied as the initial carry.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  tkm_serial_addsub_if slave: operand handshake in, result handshake out
module tkm_serial_addsub
  import tkm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  tkm_serial_addsub_if.slave bus
);

  if (WIDTH < 2 || WIDTH > TKM_SA_MAX_WIDTH) begin : g_width_check
    $error("tkm_serial_addsub: WIDTH out of range 2..TKM_SA_MAX_WIDTH");
  end

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  tkm_sa_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_q;
  logic             carry_out_q, overflow_q;
  logic             fa_s, fa_co;
  logic             accept, last_step;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_step = (state_q == RUN) && (cnt_q == LastCnt);

  tkm_full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; in_ready is masked by rst so nothing is accepted during reset.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.sum       = sum_sh_q;
    bus.carry_out = carry_out_q;
    bus.overflow  = overflow_q;
  end

  // Datapath. The sum shift register is also the result register: after WIDTH
  // shifts the first (LSB) result bit has reached bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_sh_q <= bus.op_a;
      b_sh_q <= bus.sub ? ~bus.op_b : bus.op_b;
      c_q    <= bus.sub;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
      a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
      c_q      <= fa_co;
      cnt_q    <= cnt_q + CntW'(1);
      if (last_step) begin
        // c_q here is the carry into the MSB
        carry_out_q <= fa_co;
        overflow_q  <= c_q ^ fa_co;
      end
    end
  end

endmodule
